// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: one instruction at a time
// through fetch/decode/execute/memory/write-back, stalling memory states on mem_ready_i.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       pc_en_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXE   = 4'd10, S_IWB    = 4'd11
  } state_t;

  state_t state, nxt;

  // raw decode; enables/strobes/pulses are gated by reset below
  logic       pcw, pcwc, mrd, mwr, irw, rw, done, ill;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_FETCH;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = S_FETCH;
    pcw        = 1'b0;
    pcwc       = 1'b0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    done       = 1'b0;
    ill        = 1'b0;
    IorD_o     = 1'b0;
    MemtoReg_o = 1'b0;
    RegDst_o   = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALUOp_o    = 3'b000;
    PCSource_o = 2'b00;
    case (state)
      S_FETCH: begin
        mrd       = 1'b1;
        ALUSrcB_o = 2'b01;
        irw       = mem_ready_i;
        pcw       = mem_ready_i;
        nxt       = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (op_i)
          OP_LW, OP_SW:     nxt = S_MEMADR;
          OP_R:             nxt = S_RTEXE;
          OP_BEQ:           nxt = S_BRANCH;
          OP_J:             nxt = S_JUMP;
          OP_ADDI, OP_SLTI: nxt = S_IEXE;
          default:          ill = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        nxt       = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mrd    = 1'b1;
        IorD_o = 1'b1;
        nxt    = mem_ready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        rw         = 1'b1;
        MemtoReg_o = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        mwr    = 1'b1;
        IorD_o = 1'b1;
        done   = mem_ready_i;
        nxt    = mem_ready_i ? S_FETCH : S_MEMWR;
      end
      S_RTEXE: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 3'b010;
        nxt       = S_RTWB;
      end
      S_RTWB: begin
        rw       = 1'b1;
        RegDst_o = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = 3'b001;
        pcwc       = 1'b1;
        PCSource_o = 2'b01;
        done       = 1'b1;
      end
      S_JUMP: begin
        pcw        = 1'b1;
        PCSource_o = 2'b10;
        done       = 1'b1;
      end
      S_IEXE: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = (op_i == OP_SLTI) ? 3'b011 : 3'b000;
        nxt       = S_IWB;
      end
      S_IWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset is async, so the gating must be combinational to kill strobes immediately
  assign PCWrite_o     = pcw  & rst_i;
  assign PCWriteCond_o = pcwc & rst_i;
  assign MemRead_o     = mrd  & rst_i;
  assign MemWrite_o    = mwr  & rst_i;
  assign IRWrite_o     = irw  & rst_i;
  assign RegWrite_o    = rw   & rst_i;
  assign instr_done_o  = done & rst_i;
  assign illegal_o     = ill  & rst_i;
  assign pc_en_o       = PCWrite_o | (PCWriteCond_o & zero_i);
  assign state_o       = state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives every datapath mux select and write enable, plus the 3-bit ALUOp consumed by the ALU controller. Memory accesses stall on a ready handshake.

## Interface
Parameters:
- none (encodings fixed below)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- op_i  in  6  opcode from instruction register; stable from DECODE until the next FETCH completes
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes current read/write this cycle
- PCWrite_o  out  1  unconditional PC write
- PCWriteCond_o  out  1  branch PC write qualifier
- pc_en_o  out  1  PCWrite_o | (PCWriteCond_o & zero_i)
- IorD_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead_o, MemWrite_o  out  1 each  memory strobes
- IRWrite_o  out  1  instruction register load
- MemtoReg_o  out  1  1 = MDR to register file
- RegDst_o  out  1  1 = rd, 0 = rt
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 = PC, 1 = register A
- ALUSrcB_o  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- ALUOp_o  out  3  000 add, 001 sub (beq), 010 R-type funct, 011 slt (slti)
- PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done_o  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_o  out  4  current state (debug)

## Operation
- Supported opcodes: R-type 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010.
- Outputs are Moore-decoded from the state; `ALUOp_o` in IEXE also depends on `op_i`.
- Every output not listed for a state is 0; `ALUOp_o` defaults to 000.

States and encodings:
- FETCH(0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready_i=1.
  - Stays in FETCH while mem_ready_i=0; goes to DECODE when mem_ready_i=1.
- DECODE(1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target to ALUOut).
  - Next state by opcode: lw/sw→MEMADR, R→RTEXE, beq→BRANCH, j→JUMP, addi/slti→IEXE.
  - Any other opcode: illegal_o=1, next state FETCH.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000; lw→MEMRD, sw→MEMWR.
- MEMRD(3): MemRead=1, IorD=1; waits for mem_ready_i, then MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0; →FETCH.
- MEMWR(5): MemWrite=1, IorD=1; waits for mem_ready_i, then FETCH.
- RTEXE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010; →RTWB.
- RTWB(7): RegWrite=1, RegDst=1, MemtoReg=0; →FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; →FETCH.
- JUMP(9): PCWrite=1, PCSource=10; →FETCH.
- IEXE(10): ALUSrcA=1, ALUSrcB=10; ALUOp=011 if op_i=slti, else 000; →IWB.
- IWB(11): RegWrite=1, RegDst=0, MemtoReg=0; →FETCH.
- Codes 12–15 are unreachable; if entered, all outputs are 0 and the next state is FETCH.

Handshake and pulse rules:
- instr_done_o=1 in the cycle that transitions to FETCH from MEMWB, MEMWR (with ready), RTWB, BRANCH, JUMP or IWB. It is not asserted for illegal opcodes.
- MemRead/MemWrite are held steady through a stall. IorD does not change while a strobe is high.

## Timing
- With rst_i low: state=FETCH (0) asynchronously, and all write enables, strobes and pulses are forced to 0. These are PCWrite, PCWriteCond, pc_en, MemRead, MemWrite, IRWrite, RegWrite, instr_done and illegal. Selects take their FETCH values.
- The first FETCH cycle begins at the first rising edge after rst_i rises.
- Cycles per instruction with mem_ready_i always 1: lw 5, sw 4, R/addi/slti 4, beq 3, j 3. Each cycle with mem_ready_i=0 in FETCH, MEMRD or MEMWR adds 1.
- pc_en_o is combinational from zero_i in BRANCH, with no extra cycle.
- Reset asserted mid-instruction aborts it: no write enable is asserted after the reset edge, and execution restarts at FETCH.

## Test plan
- Reset then add: op_i=000000, ready=1 → states 0,1,6,7,0. ALUOp=010 in state 6. RegWrite=1, RegDst=1 in state 7. instr_done pulses once.
- lw with ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0 (7 cycles). MemRead=1, IorD=1 throughout state 3. MemtoReg=1 in state 4.
- beq with zero_i=1 → pc_en=1 and PCSource=01 in state 8. Repeated with zero_i=0 → pc_en=0. Both take 3 cycles.
- slti vs addi → ALUOp=011 vs 000 in state 10. ALUSrcB=10 in both.
- Illegal opcode 111111 → illegal_o pulses in state 1, next state 0, no RegWrite/MemWrite, no instr_done.
- rst_i dropped during MEMWR with ready low → MemWrite falls immediately and state_o=0. After release, FETCH restarts.
